microwave_ctrl: RTL and testbench

Cooking-time controller for the microwave design. It consumes the one-clock button pulses from the debouncers plus a door-switch level, and holds a minutes:seconds cook time set by the user. It counts that time down at 1 Hz while driving the magnetron/turntable enable, then sounds the buzzer. Its outputs feed the FND display driver and the actuator/buzzer outputs.

---
 rtl/microwave_pkg.sv | 16 +
 rtl/sec_tick_gen.sv | 29 ++
 rtl/microwave_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_microwave_ctrl.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/microwave_pkg.sv
// Shared types and limits for the microwave cook-time controller.
package microwave_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SET   = 3'd1,
      ST_RUN   = 3'd2,
      ST_PAUSE = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   localparam int MAX_MIN  = 99;
   localparam int MAX_SEC  = 59;
   localparam int SEC_STEP = 10;

endpackage

// File: rtl/sec_tick_gen.sv
// 1 s prescaler: pulses tick on the last count of each period; clr wins over en.
module sec_tick_gen #(
   parameter int TICK_COUNT = 100_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam int W = (TICK_COUNT > 1) ? $clog2(TICK_COUNT) : 1;
   localparam logic [W-1:0] LAST = W'(TICK_COUNT - 1);

   logic [W-1:0] cnt;

   assign tick = en && (cnt == LAST);

   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= (cnt == LAST) ? '0 : cnt + W'(1);
      end
   end

endmodule

// File: rtl/microwave_ctrl.sv
// Cook-time controller: button-driven mm:ss entry, 1 Hz countdown, buzzer on completion.
//
//   state | meaning
//   IDLE  | time 0:00, waiting for an add
//   SET   | time entered, waiting for start
//   RUN   | magnetron on, counting down
//   PAUSE | stopped by stop button or door, prescaler frozen
//   DONE  | buzzer on for BUZZ_SEC seconds
module microwave_ctrl
   import microwave_pkg::*;
#(
   parameter int TICK_COUNT = 100_000_000,
   parameter int BUZZ_SEC   = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_btn_start,
   input  logic       i_btn_stop,
   input  logic       i_btn_min,
   input  logic       i_btn_sec,
   input  logic       i_door_open,
   output logic [6:0] o_min,
   output logic [5:0] o_sec,
   output logic [2:0] o_state,
   output logic       o_run,
   output logic       o_buzzer,
   output logic       o_done
);

   localparam int BW = $clog2(BUZZ_SEC + 1);

   state_t          state, state_nx;
   logic [6:0]      min_q, min_nx, add_min, dec_min;
   logic [5:0]      sec_q, sec_nx, add_sec, dec_sec;
   logic [BW-1:0]   buzz_q, buzz_nx;
   logic            done_nx;
   logic            tick, pre_en, pre_clr;
   logic            ev_stop, ev_start, ev_min, ev_sec, ev_add, any_btn;
   logic            carry, time_zero, last_sec;

   // one event per cycle: stop > start > min > sec
   assign ev_stop  = i_btn_stop;
   assign ev_start = i_btn_start & ~i_btn_stop;
   assign ev_min   = i_btn_min & ~i_btn_start & ~i_btn_stop;
   assign ev_sec   = i_btn_sec & ~i_btn_min & ~i_btn_start & ~i_btn_stop;
   assign ev_add   = ev_min | ev_sec;
   assign any_btn  = i_btn_start | i_btn_stop | i_btn_min | i_btn_sec;

   assign time_zero = (min_q == 7'd0) && (sec_q == 6'd0);
   assign last_sec  = (min_q == 7'd0) && (sec_q == 6'd1);
   assign pre_en    = (state == ST_RUN) || (state == ST_DONE);

   sec_tick_gen #(.TICK_COUNT(TICK_COUNT)) u_tick (
      .clk  (clk),
      .rst  (rst),
      .en   (pre_en),
      .clr  (pre_clr),
      .tick (tick)
   );

   always_comb begin
      add_min = min_q;
      add_sec = sec_q;
      carry   = 1'b0;
      if (ev_min) begin
         carry = 1'b1;
      end else if (sec_q >= 6'(MAX_SEC + 1 - SEC_STEP)) begin
         add_sec = sec_q - 6'(MAX_SEC + 1 - SEC_STEP);
         carry   = 1'b1;
      end else begin
         add_sec = sec_q + 6'(SEC_STEP);
      end
      if (carry) begin
         if (min_q == 7'(MAX_MIN)) begin
            add_min = 7'(MAX_MIN);
            add_sec = 6'(MAX_SEC);
         end else begin
            add_min = min_q + 7'd1;
         end
      end
   end

   always_comb begin
      dec_min = min_q;
      dec_sec = sec_q - 6'd1;
      if (sec_q == 6'd0) begin
         dec_min = min_q - 7'd1;
         dec_sec = 6'(MAX_SEC);
      end
   end

   always_comb begin
      state_nx = state;
      min_nx   = min_q;
      sec_nx   = sec_q;
      buzz_nx  = buzz_q;
      done_nx  = 1'b0;
      pre_clr  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (ev_add) begin
               min_nx   = add_min;
               sec_nx   = add_sec;
               state_nx = ST_SET;
            end
         end
         ST_SET, ST_PAUSE: begin
            if (ev_stop) begin
               min_nx   = '0;
               sec_nx   = '0;
               state_nx = ST_IDLE;
            end else if (ev_start) begin
               if (!i_door_open && !time_zero) begin
                  state_nx = ST_RUN;
                  pre_clr  = (state == ST_SET);
               end
            end else if (ev_add) begin
               min_nx = add_min;
               sec_nx = add_sec;
            end
         end
         ST_RUN: begin
            // leaving RUN drops any tick landing in the same cycle
            if (ev_stop || i_door_open) begin
               state_nx = ST_PAUSE;
            end else if (tick) begin
               min_nx = dec_min;
               sec_nx = dec_sec;
               if (last_sec) begin
                  state_nx = ST_DONE;
                  done_nx  = 1'b1;
                  pre_clr  = 1'b1;
                  buzz_nx  = BW'(BUZZ_SEC);
               end
            end
         end
         ST_DONE: begin
            if (any_btn) begin
               state_nx = ST_IDLE;
            end else if (tick) begin
               if (buzz_q <= BW'(1)) begin
                  state_nx = ST_IDLE;
               end else begin
                  buzz_nx = buzz_q - BW'(1);
               end
            end
         end
         default: begin
            state_nx = ST_IDLE;
            min_nx   = '0;
            sec_nx   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= ST_IDLE;
         min_q    <= '0;
         sec_q    <= '0;
         buzz_q   <= '0;
         o_run    <= 1'b0;
         o_buzzer <= 1'b0;
         o_done   <= 1'b0;
      end else begin
         state    <= state_nx;
         min_q    <= min_nx;
         sec_q    <= sec_nx;
         buzz_q   <= buzz_nx;
         o_run    <= (state_nx == ST_RUN);
         o_buzzer <= (state_nx == ST_DONE);
         o_done   <= done_nx;
      end
   end

   assign o_min   = min_q;
   assign o_sec   = sec_q;
   assign o_state = state;

endmodule

// File: tb/tb_microwave_ctrl.sv
// Self-checking bench for microwave_ctrl: directed timing scenarios plus random button traffic.
module tb_microwave_ctrl;

   localparam int TC = 10;
   localparam int BZ = 2;
   localparam int M_IDLE = 0, M_SET = 1, M_RUN = 2, M_PAUSE = 3, M_DONE = 4;
   localparam int MAX_T = 99 * 60 + 59;

   logic       clk = 1'b0;
   logic       rst;
   logic       btn_start, btn_stop, btn_min, btn_sec, door;
   logic [6:0] o_min;
   logic [5:0] o_sec;
   logic [2:0] o_state;
   logic       o_run, o_buzzer, o_done;

   int checks = 0;
   int failures = 0;

   // reference model: time kept as total seconds, phase as cycles into the current second
   int m_state, m_t, m_ph, m_bz, m_done;

   microwave_ctrl #(.TICK_COUNT(TC), .BUZZ_SEC(BZ)) dut (
      .clk         (clk),
      .rst         (rst),
      .i_btn_start (btn_start),
      .i_btn_stop  (btn_stop),
      .i_btn_min   (btn_min),
      .i_btn_sec   (btn_sec),
      .i_door_open (door),
      .o_min       (o_min),
      .o_sec       (o_sec),
      .o_state     (o_state),
      .o_run       (o_run),
      .o_buzzer    (o_buzzer),
      .o_done      (o_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic int sat(input int v);
      return (v > MAX_T) ? MAX_T : v;
   endfunction

   task automatic model_step(input logic r, input logic sp, input logic st,
                             input logic mn, input logic sc, input logic dr);
      logic tk;
      int   add;
      if (!r) begin
         m_state = M_IDLE; m_t = 0; m_ph = 0; m_bz = 0; m_done = 0;
         return;
      end
      tk = (m_state == M_RUN || m_state == M_DONE) && (m_ph == TC - 1);
      if (m_state == M_RUN || m_state == M_DONE) m_ph = (m_ph + 1) % TC;
      add = 0;
      if (!sp && !st) add = mn ? 60 : (sc ? 10 : 0);
      m_done = 0;
      case (m_state)
         M_IDLE: if (add != 0) begin m_t = sat(m_t + add); m_state = M_SET; end
         M_SET, M_PAUSE: begin
            if (sp) begin
               m_t = 0; m_state = M_IDLE;
            end else if (st) begin
               if (!dr && m_t > 0) begin
                  if (m_state == M_SET) m_ph = 0;
                  m_state = M_RUN;
               end
            end else if (add != 0) begin
               m_t = sat(m_t + add);
            end
         end
         M_RUN: begin
            if (sp || dr) m_state = M_PAUSE;
            else if (tk) begin
               m_t = m_t - 1;
               if (m_t == 0) begin
                  m_state = M_DONE; m_done = 1; m_ph = 0; m_bz = 0;
               end
            end
         end
         M_DONE: begin
            if (sp || st || mn || sc) m_state = M_IDLE;
            else if (tk) begin
               m_bz++;
               if (m_bz == BZ) m_state = M_IDLE;
            end
         end
         default: m_state = M_IDLE;
      endcase
   endtask

   task automatic compare_all();
      chk("state",  32'(o_state),  32'(m_state));
      chk("min",    32'(o_min),    32'(m_t / 60));
      chk("sec",    32'(o_sec),    32'(m_t % 60));
      chk("run",    32'(o_run),    32'(m_state == M_RUN));
      chk("buzzer", 32'(o_buzzer), 32'(m_state == M_DONE));
      chk("done",   32'(o_done),   32'(m_done));
   endtask

   task automatic step(input logic r, input logic sp, input logic st,
                       input logic mn, input logic sc);
      rst = r; btn_stop = sp; btn_start = st; btn_min = mn; btn_sec = sc;
      @(posedge clk);
      model_step(r, sp, st, mn, sc, door);
      #1;
      compare_all();
      rst = 1'b1; btn_stop = 1'b0; btn_start = 1'b0; btn_min = 1'b0; btn_sec = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0);
   endtask

   task automatic chk_time(input string tag, input int mm, input int ss);
      chk(tag, {25'd0, o_min}, 32'(mm));
      chk(tag, {26'd0, o_sec}, 32'(ss));
   endtask

   initial begin
      int n;
      rst = 1'b0; btn_start = 0; btn_stop = 0; btn_min = 0; btn_sec = 0; door = 0;
      m_state = M_IDLE; m_t = 0; m_ph = 0; m_bz = 0; m_done = 0;

      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      chk("reset_state", 32'(o_state), 32'(M_IDLE));
      chk_time("reset_time", 0, 0);

      // entry with carry
      repeat (3) step(1, 0, 0, 0, 1);
      chk("t1_set", 32'(o_state), 32'(M_SET));
      chk_time("t1_030", 0, 30);
      step(1, 0, 0, 1, 0);
      chk_time("t1_130", 1, 30);
      repeat (4) step(1, 0, 0, 0, 1);
      chk_time("t1_210", 2, 10);

      // saturation
      step(1, 1, 0, 0, 0);
      repeat (98) step(1, 0, 0, 1, 0);
      repeat (5) step(1, 0, 0, 0, 1);
      chk_time("t2_9850", 98, 50);
      step(1, 0, 0, 1, 0);
      chk_time("t2_9950", 99, 50);
      step(1, 0, 0, 0, 1);
      chk_time("t2_sat_sec", 99, 59);
      step(1, 0, 0, 1, 0);
      chk_time("t2_sat_min", 99, 59);

      // full countdown, done pulse and buzzer length
      step(1, 1, 0, 0, 0);
      step(1, 0, 0, 0, 1);
      step(1, 0, 1, 0, 0);
      chk("t3_run_latency", 32'(o_run), 32'd1);
      n = 1;
      while (!o_done && n < 300) begin step(1, 0, 0, 0, 0); n++; end
      chk("t3_done_cycle", 32'(n), 32'd101);
      chk("t3_done_state", 32'(o_state), 32'(M_DONE));
      n = 0;
      while (o_buzzer && n < 100) begin n++; step(1, 0, 0, 0, 0); end
      chk("t3_buzz_len", 32'(n), 32'(BZ * TC));
      chk("t3_back_idle", 32'(o_state), 32'(M_IDLE));

      // door pause, blocked start, frozen prescaler
      step(1, 0, 0, 0, 1);
      step(1, 0, 1, 0, 0);
      idle(14);
      door = 1'b1;
      step(1, 0, 0, 0, 0);
      chk("t4_pause", 32'(o_state), 32'(M_PAUSE));
      chk("t4_run_off", 32'(o_run), 32'd0);
      chk_time("t4_time", 0, 9);
      step(1, 0, 1, 0, 0);
      chk("t4_door_blocks", 32'(o_state), 32'(M_PAUSE));
      door = 1'b0;
      step(1, 0, 1, 0, 0);
      chk("t4_resume", 32'(o_state), 32'(M_RUN));
      n = 0;
      while (o_sec == 6'd9 && n < 30) begin step(1, 0, 0, 0, 0); n++; end
      chk("t4_resume_phase", 32'(n), 32'd5);
      step(1, 1, 0, 0, 0);
      step(1, 1, 0, 0, 0);

      // start+stop together, tick+door together
      step(1, 0, 0, 0, 1);
      step(1, 1, 1, 0, 0);
      chk("t5_stop_wins", 32'(o_state), 32'(M_IDLE));
      chk_time("t5_cleared", 0, 0);
      step(1, 0, 0, 0, 1);
      step(1, 0, 1, 0, 0);
      idle(9);
      door = 1'b1;
      step(1, 0, 0, 0, 0);
      chk("t5_door_tick", 32'(o_state), 32'(M_PAUSE));
      chk_time("t5_no_dec", 0, 10);
      door = 1'b0;
      step(1, 1, 0, 0, 0);

      // reset mid-run, button abort in DONE
      step(1, 0, 0, 0, 1);
      step(1, 0, 1, 0, 0);
      idle(5);
      step(0, 0, 0, 0, 0);
      chk("t6_rst_state", 32'(o_state), 32'(M_IDLE));
      chk("t6_rst_done", 32'(o_done), 32'd0);
      step(1, 0, 0, 0, 1);
      step(1, 0, 1, 0, 0);
      n = 0;
      while (o_state != 3'(M_DONE) && n < 300) begin step(1, 0, 0, 0, 0); n++; end
      chk("t6_reach_done", 32'(o_state), 32'(M_DONE));
      step(1, 0, 0, 1, 0);
      chk("t6_abort_idle", 32'(o_state), 32'(M_IDLE));
      chk("t6_abort_buzz", 32'(o_buzzer), 32'd0);
      chk_time("t6_no_add", 0, 0);

      // random traffic against the model
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 49) == 0) door = ~door;
         step(($urandom_range(0, 499) != 0),
              ($urandom_range(0, 39) == 0),
              ($urandom_range(0, 7) == 0),
              ($urandom_range(0, 59) == 0),
              ($urandom_range(0, 9) == 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
